simple_unshuffler: RTL

SIMPLE_UNSHUFFLER -- requirements
Module: simple_unshuffler

---
 rtl/simple_unshuffler_pkg.sv | 22 ++
 rtl/unshuffler_tile_buf.sv | 63 ++++++
 rtl/simple_unshuffler.sv | 92 +++++++++
 3 files changed

// File: rtl/simple_unshuffler_pkg.sv
// Shared types and sizing helpers for the tile unshuffler.
// The FILL/DRAIN buffer state and the element/beat count helpers live here.
package simple_unshuffler_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } buf_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_ELEM_WIDTH = 8;
    localparam int unsigned DEF_ELEMS      = DEF_DATA_WIDTH / DEF_ELEM_WIDTH;

    function automatic int unsigned elems_per_beat(input int unsigned dw, input int unsigned ew);
        return dw / ew;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unshuffler_tile_buf.sv
// One N x N element tile buffer: fills row-wise, drains column-wise (transposed).
// Write and read are mutually exclusive by state, so one buffer never sees both.
module unshuffler_tile_buf
    import simple_unshuffler_pkg::*;
#(
    parameter int unsigned DataWidth = DEF_DATA_WIDTH,
    parameter int unsigned ElemWidth = DEF_ELEM_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output buf_state_e           state_o,
    output logic [DataWidth-1:0] rd_data_o,
    output logic                 last_wr_o,
    output logic                 last_rd_o
);
    localparam int unsigned N    = elems_per_beat(DataWidth, ElemWidth);
    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

    logic [N-1:0][DataWidth-1:0] mem_q;
    logic [CntW-1:0]             wr_cnt_q, rd_cnt_q;
    buf_state_e                  state_q;
    logic [31:0]                 rd_base;

    assign state_o   = state_q;
    assign last_wr_o = (wr_cnt_q == LastIdx);
    assign last_rd_o = (rd_cnt_q == LastIdx);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            mem_q    <= '0;
        end else begin
            case (state_q)
                FILL: if (wr_en_i) begin
                    mem_q[wr_cnt_q] <= wr_data_i;
                    wr_cnt_q        <= last_wr_o ? '0 : wr_cnt_q + 1'b1;
                    if (last_wr_o) state_q <= DRAIN;
                end
                DRAIN: if (rd_en_i) begin
                    rd_cnt_q <= last_rd_o ? '0 : rd_cnt_q + 1'b1;
                    if (last_rd_o) state_q <= FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Output beat r gathers element r of every stored input beat.
    assign rd_base = 32'(rd_cnt_q) * ElemWidth;

    always_comb begin
        rd_data_o = '0;
        for (int c = 0; c < N; c++)
            rd_data_o[c*ElemWidth +: ElemWidth] = mem_q[c][rd_base +: ElemWidth];
    end

endmodule

// File: rtl/simple_unshuffler.sv
// Element-wise tile transposer; SIMPLE_UNSHUFFLER_PINGPONG_EN selects two
// alternating tile buffers instead of one (single buffer when undefined).
module simple_unshuffler
    import simple_unshuffler_pkg::*;
#(
    parameter int unsigned DataWidth = DEF_DATA_WIDTH,
    parameter int unsigned ElemWidth = DEF_ELEM_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 tile_done_o
);
`ifdef SIMPLE_UNSHUFFLER_PINGPONG_EN
    localparam int unsigned NumBufs = 2;
`else
    localparam int unsigned NumBufs = 1;
`endif

    logic [NumBufs-1:0]   wr_en, rd_en, last_wr, last_rd;
    buf_state_e           st      [NumBufs];
    logic [DataWidth-1:0] rd_data [NumBufs];
    logic [DataWidth-1:0] rd_beat;
    logic                 rd_last, in_hs, out_hs;

    assign in_hs  = data_valid_i && data_ready_o;
    assign out_hs = data_valid_o && data_ready_i;

    for (genvar b = 0; b < NumBufs; b++) begin : g_buf
        unshuffler_tile_buf #(
            .DataWidth(DataWidth),
            .ElemWidth(ElemWidth)
        ) u_buf (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .wr_en_i  (wr_en[b]),
            .wr_data_i(data_i),
            .rd_en_i  (rd_en[b]),
            .state_o  (st[b]),
            .rd_data_o(rd_data[b]),
            .last_wr_o(last_wr[b]),
            .last_rd_o(last_rd[b])
        );
    end

`ifdef SIMPLE_UNSHUFFLER_PINGPONG_EN
    logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;

    // Selectors flip on the last beat of a tile, so buffers strictly alternate.
    assign wr_sel_d = wr_sel_q ^ (in_hs && last_wr[wr_sel_q]);
    assign rd_sel_d = rd_sel_q ^ (out_hs && last_rd[rd_sel_q]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    for (genvar b = 0; b < NumBufs; b++) begin : g_sel
        assign wr_en[b] = in_hs  && (wr_sel_q == 1'(b));
        assign rd_en[b] = out_hs && (rd_sel_q == 1'(b));
    end

    assign data_ready_o = (st[wr_sel_q] == FILL);
    assign data_valid_o = (st[rd_sel_q] == DRAIN);
    assign rd_beat      = rd_data[rd_sel_q];
    assign rd_last      = last_rd[rd_sel_q];
`else
    logic unused_last_wr;

    assign unused_last_wr = last_wr[0];
    assign wr_en          = in_hs;
    assign rd_en          = out_hs;
    assign data_ready_o   = (st[0] == FILL);
    assign data_valid_o   = (st[0] == DRAIN);
    assign rd_beat        = rd_data[0];
    assign rd_last        = last_rd[0];
`endif

    assign data_o      = data_valid_o ? rd_beat : '0;
    assign tile_done_o = out_hs && rd_last;

endmodule
